reg_rv_slice: RTL
=================

// Module: reg_rv_slice
// PURPOSE
// - Valid/ready pipeline register slice (2-entry skid buffer) for streaming datapaths.
// - Handshaked counterpart of the plain pipeline register:
//   - upstream producer writes words in on the s_ side;
//   - downstream consumer reads them out on the m_ side.
// - Breaks combinational timing paths in both directions: data/valid forward, ready backward.
// - Sustains 1 word/cycle throughput.
// PARAMETERS
// - width  default 64  data word width in bits
// PORTS
// - clk        in   1      clock; all state updates on posedge
// - rst        in   1      reset, synchronous, active-high
// - s_data     in   width  upstream data word
// - s_valid    in   1      upstream word valid
// - s_ready    out  1      slice can accept a word this cycle
// - m_data     out  width  downstream data word
// - m_valid    out  1      m_data holds a valid word
// - m_ready    in   1      downstream accepts m_data this cycle
// - occupancy  out  2      number of buffered words, 0..2
// BEHAVIOUR
// - Clock and reset:
//   - one clock, clk;
//   - rst is synchronous, active-high, and sampled only at posedge clk;
//   - rst has priority over every other event.
// - Handshake events:
//   - push = s_valid & s_ready;
//   - pop  = m_valid & m_ready.
// - Storage: main_q is the output register and drives m_data; skid_q is the overflow register.
// - States: EMPTY (occupancy=0), ONE (occupancy=1), FULL (occupancy=2).
// - Output decode, from state flops only:
//   - m_valid = (state != EMPTY);
//   - s_ready = (state != FULL).
//   - No combinational path from m_ready to s_ready, or from s_valid to m_valid.
// - Transitions:
//   - EMPTY, push: main_q <= s_data; go to ONE.
//   - ONE, push & pop: main_q <= s_data; stay in ONE.
//   - ONE, push & !pop: skid_q <= s_data; go to FULL.
//   - ONE, pop & !push: go to EMPTY.
//   - FULL, pop: main_q <= skid_q; go to ONE. No push is possible, since s_ready=0.
//   - No event: hold state and registers.
// - Reset values:
//   - state = EMPTY;
//   - m_valid = 0, s_ready = 1, occupancy = 0;
//   - main_q = 0, skid_q = 0, so m_data = 0.
// - Latency: a word pushed at edge N is presented on m_data with m_valid=1 after edge N. That is 1 cycle, with no bypass.
// - Ordering:
//   - strict FIFO order;
//   - no word is dropped or duplicated;
//   - m_data is stable while m_valid=1 and m_ready=0.
// - s_valid=1 while s_ready=0: no effect. The upstream must hold its word.
// - s_data is ignored whenever push=0.
// - Reset mid-operation: all buffered words are discarded; state returns to EMPTY on that edge.
// - occupancy always equals the number of valid stored words. It never exceeds 2.
// TESTING
// - Reset: assert rst for 2 cycles with s_valid=1 -> m_valid=0, s_ready=1, occupancy=0, m_data=0.
// - Streaming: s_valid=1 with 0x1,0x2,...,0x10 on consecutive cycles, m_ready=1 -> m_data 0x1..0x10, 1-cycle lag, s_ready=1 throughout.
// - Backpressure:
//   - push 0xA then 0xB with m_ready=0 -> occupancy=2, s_ready=0, m_data=0xA held;
//   - then raise m_ready -> 0xA, then 0xB.
// - Blocked input: in FULL, drive s_valid=1 with s_data=0xDEAD for 3 cycles -> no capture; output order unchanged.
// - Mid-operation reset: in FULL, pulse rst for 1 cycle -> next cycle occupancy=0, m_valid=0, s_ready=1; no stale word emerges.
// - Random stress: 10k cycles of random s_valid/m_ready vs. a scoreboard queue.
//   - Required: in-order delivery, 0 losses;
//   - m_data stable under stall;
//   - occupancy equal to the scoreboard depth.

Source files
------------

// File: rtl/reg_rv_slice.sv
// reg_rv_slice: two-entry valid/ready skid buffer.
//
// Decouples an upstream producer (s_ side) from a downstream consumer
// (m_ side). It registers data/valid in the forward direction and ready in
// the backward direction, and still sustains one word per cycle.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   s_data     upstream word
//   s_valid    upstream word valid
//   s_ready    slice can take a word this cycle
//   m_data     downstream word (always the output register main_q)
//   m_valid    m_data holds a valid word
//   m_ready    downstream takes m_data this cycle
//   occupancy  number of words held, 0..2
//
// state | meaning
// ------+-----------------------------------------------
// EMPTY | nothing buffered, m_valid=0, s_ready=1
// ONE   | main_q holds the head word, skid_q unused
// FULL  | main_q holds the head, skid_q the next word, s_ready=0

module reg_rv_slice #(
    parameter int width = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [width-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [1:0]       occupancy
);

    // The encoding equals the word count, so occupancy is the state itself.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    logic [width-1:0] main_q;
    logic [width-1:0] skid_q;
    logic             push;
    logic             pop;

    // Both handshake outputs decode from the state flop only. This keeps
    // m_ready and s_valid off any combinational path to the opposite side.
    assign m_valid   = (state != EMPTY);
    assign s_ready   = (state != FULL);
    assign occupancy = state;
    assign m_data    = main_q;

    assign push = s_valid & s_ready;
    assign pop  = m_valid & m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        main_q <= s_data;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_q <= s_data;
                    end else if (push) begin
                        skid_q <= s_data;
                        state  <= FULL;
                    end else if (pop) begin
                        state  <= EMPTY;
                    end
                end
                FULL: begin
                    // s_ready is low here, so only a pop can happen.
                    if (pop) begin
                        main_q <= skid_q;
                        state  <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule
